// File: rtl/instruction_fetch_unit.sv
// Fetch front end: issues in-order word fetches at the PC, buffers returned words with their
// addresses, and hands one instruction per cycle to the decoder with stall and redirect handling.
module instruction_fetch_unit #(
    parameter int                    instructionWidth = 32,
    parameter int                    addressSize      = 64,
    parameter int                    bufferDepth      = 4,
    parameter int                    ptrWidth         = 2,
    parameter logic [0:addressSize-1] resetAddress    = '0
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic                        enable_i,
    input  logic                        stall_i,
    input  logic                        redirect_i,
    input  logic [0:addressSize-1]      redirectAddress_i,
    output logic                        memReq_o,
    output logic [0:addressSize-1]      memAddress_o,
    input  logic                        memReady_i,
    input  logic                        memValid_i,
    input  logic [0:instructionWidth-1] memData_i,
    output logic [0:instructionWidth-1] instruction_o,
    output logic [0:addressSize-1]      address_o,
    output logic                        enable_o
);

    localparam int CountWidth = ptrWidth + 1;
    // Stale responses can pile up across back-to-back redirects, so give drop_count headroom.
    localparam int DropWidth  = ptrWidth + 4;

    logic [0:addressSize-1]      pc;
    logic [ptrWidth-1:0]         head;
    logic [ptrWidth-1:0]         tail;
    logic [ptrWidth-1:0]         fill;
    logic [CountWidth-1:0]       count;
    logic [CountWidth-1:0]       pending;
    logic [DropWidth-1:0]        drop_count;
    logic [0:addressSize-1]      entry_addr  [bufferDepth];
    logic [0:instructionWidth-1] entry_instr [bufferDepth];
    logic [bufferDepth-1:0]      entry_filled;

    logic                        full;
    logic                        accept;
    logic                        drop_word;
    logic                        fill_word;
    logic                        emit;
    logic [DropWidth-1:0]        stale;
    logic [DropWidth-1:0]        drop_next;

    always_comb begin
        full         = (count == CountWidth'(bufferDepth));
        memReq_o     = reset_i & enable_i & ~redirect_i & ~full;
        memAddress_o = pc;
        accept       = memReq_o & memReady_i;
        drop_word    = memValid_i & (drop_count != '0);
        fill_word    = memValid_i & (drop_count == '0) & (pending != '0);
        emit         = ~stall_i & ~redirect_i & entry_filled[head];
        // On redirect every word still in flight becomes stale, less one arriving right now.
        stale        = DropWidth'(pending) + drop_count;
        drop_next    = stale - DropWidth'(memValid_i && (stale != '0));
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            pc            <= resetAddress;
            head          <= '0;
            tail          <= '0;
            fill          <= '0;
            count         <= '0;
            pending       <= '0;
            drop_count    <= '0;
            entry_filled  <= '0;
            enable_o      <= 1'b0;
            instruction_o <= '0;
            address_o     <= '0;
        end else if (redirect_i) begin
            pc           <= {redirectAddress_i[0:addressSize-3], 2'b00};
            head         <= '0;
            tail         <= '0;
            fill         <= '0;
            count        <= '0;
            pending      <= '0;
            drop_count   <= drop_next;
            entry_filled <= '0;
            enable_o     <= 1'b0;
        end else begin
            if (accept) begin
                tail               <= tail + ptrWidth'(1);
                pc                 <= pc + addressSize'(4);
                entry_filled[tail] <= 1'b0;
            end
            if (drop_word) begin
                drop_count <= drop_count - DropWidth'(1);
            end
            if (fill_word) begin
                fill               <= fill + ptrWidth'(1);
                entry_filled[fill] <= 1'b1;
            end
            if (emit) begin
                instruction_o      <= entry_instr[head];
                address_o          <= entry_addr[head];
                head               <= head + ptrWidth'(1);
                entry_filled[head] <= 1'b0;
                enable_o           <= 1'b1;
            end else begin
                enable_o <= 1'b0;
            end
            count   <= count + CountWidth'(accept) - CountWidth'(emit);
            pending <= pending + CountWidth'(accept) - CountWidth'(fill_word);
        end
    end

    always_ff @(posedge clock_i) begin
        if (accept) begin
            entry_addr[tail] <= pc;
        end
        if (fill_word) begin
            entry_instr[fill] <= memData_i;
        end
    end

endmodule
